// File: rtl/instr_fetch_queue.sv
// Fetch-to-decode decoupling queue: circular FIFO of {pc, instr} pairs feeding a
// registered instruction_reg, with same-edge bypass when empty and flush on redirect.
module instr_fetch_queue #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic                      cpu_clk_gated,
   input  logic                      i_rstn,
   input  logic                      if_valid,
   input  logic [XLEN-1:0]           if_pc,
   input  logic [XLEN-1:0]           if_instr,
   output logic                      if_ready,
   input  logic                      id_ready,
   input  logic                      flush,
   output logic [2*XLEN:0]           instruction_reg,
   output logic [$clog2(DEPTH):0]    occupancy
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int DW = 2 * XLEN;
   localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);
   localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic          empty;
   logic          push;
   logic          mem_we;

   assign occupancy = wr_ptr - rd_ptr;
   assign empty     = (rd_ptr == wr_ptr);
   assign if_ready  = (occupancy != FULL_CNT);
   assign push      = if_valid & if_ready;
   // An accepted word goes to the FIFO unless flushed or bypassed straight to decode.
   assign mem_we    = push & ~flush & ~(id_ready & empty);

   // Storage stage: data only, never reset
   always_ff @(posedge cpu_clk_gated) begin
      if (mem_we) begin
         mem[wr_ptr[AW-1:0]] <= {if_pc, if_instr};
      end
   end

   // Control and decode-register stage
   always_ff @(posedge cpu_clk_gated or negedge i_rstn) begin
      if (!i_rstn) begin
         rd_ptr          <= '0;
         wr_ptr          <= '0;
         instruction_reg <= '0;
      end else if (flush) begin
         rd_ptr              <= wr_ptr;
         instruction_reg[DW] <= 1'b0;
      end else begin
         if (mem_we) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (id_ready) begin
            if (!empty) begin
               instruction_reg <= {1'b1, mem[rd_ptr[AW-1:0]]};
               rd_ptr          <= rd_ptr + PTR_ONE;
            end else if (push) begin
               instruction_reg <= {1'b1, if_pc, if_instr};
            end else begin
               instruction_reg[DW] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: bypass, backpressure, ordering, wrap,
// flush, gated clock and asynchronous reset.
module tb_instr_fetch_queue;

   localparam int DEPTH = 4;
   localparam int XLEN  = 32;

   logic              aon_clk;
   logic              clk_en;
   logic              cpu_clk_gated;
   logic              i_rstn;
   logic              if_valid;
   logic [XLEN-1:0]   if_pc;
   logic [XLEN-1:0]   if_instr;
   logic              if_ready;
   logic              id_ready;
   logic              flush;
   logic [2*XLEN:0]   instruction_reg;
   logic [2:0]        occupancy;

   int tests;
   int fails;

   instr_fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .cpu_clk_gated   (cpu_clk_gated),
      .i_rstn          (i_rstn),
      .if_valid        (if_valid),
      .if_pc           (if_pc),
      .if_instr        (if_instr),
      .if_ready        (if_ready),
      .id_ready        (id_ready),
      .flush           (flush),
      .instruction_reg (instruction_reg),
      .occupancy       (occupancy)
   );

   initial aon_clk = 1'b0;
   always #5 aon_clk = ~aon_clk;
   assign cpu_clk_gated = aon_clk & clk_en;

   function automatic logic [31:0] instr_of(input logic [31:0] pc);
      return 32'hA000_0000 | pc;
   endfunction

   function automatic logic [64:0] exp_ir(input logic [31:0] pc);
      return {1'b1, pc, instr_of(pc)};
   endfunction

   task automatic drive(input logic v, input logic [31:0] pc, input logic idr, input logic fl);
      if_valid = v;
      if_pc    = pc;
      if_instr = instr_of(pc);
      id_ready = idr;
      flush    = fl;
   endtask

   task automatic tick();
      @(posedge aon_clk);
      #1;
   endtask

   task automatic test_reset();
      tests++;
      if (instruction_reg !== 65'd0) begin
         fails++; $display("FAIL reset_ir got=%h want=0", instruction_reg);
      end
      tests++;
      if (occupancy !== 3'd0 || if_ready !== 1'b1) begin
         fails++; $display("FAIL reset_ctrl occ=%0d rdy=%b want occ=0 rdy=1", occupancy, if_ready);
      end
   endtask

   task automatic test_bypass();
      drive(1'b1, 32'h100, 1'b1, 1'b0);
      if_instr = 32'h0050_0093;
      tick();
      tests++;
      if (instruction_reg !== {1'b1, 32'h100, 32'h0050_0093} || occupancy !== 3'd0) begin
         fails++; $display("FAIL bypass ir=%h occ=%0d want ir=%h occ=0",
                           instruction_reg, occupancy, {1'b1, 32'h100, 32'h0050_0093});
      end
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      tick();
      tests++;
      if (instruction_reg !== {1'b0, 32'h100, 32'h0050_0093}) begin
         fails++; $display("FAIL bypass_idle ir=%h want valid=0 fields held", instruction_reg);
      end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'(i * 4), 1'b0, 1'b0);
         tick();
      end
      tests++;
      if (occupancy !== 3'd4 || if_ready !== 1'b0) begin
         fails++; $display("FAIL fill occ=%0d rdy=%b want occ=4 rdy=0", occupancy, if_ready);
      end
      drive(1'b1, 32'h10, 1'b0, 1'b0);
      tick();
      tick();
      tests++;
      if (occupancy !== 3'd4 || instruction_reg[64] !== 1'b0) begin
         fails++; $display("FAIL full_reject occ=%0d vld=%b want occ=4 vld=0",
                           occupancy, instruction_reg[64]);
      end
   endtask

   task automatic test_drain();
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tick();
         tests++;
         if (instruction_reg !== exp_ir(32'(i * 4)) || occupancy !== 3'(3 - i)) begin
            fails++; $display("FAIL drain_%0d ir=%h occ=%0d want ir=%h occ=%0d",
                              i, instruction_reg, occupancy, exp_ir(32'(i * 4)), 3 - i);
         end
      end
      tick();
      tests++;
      if (instruction_reg[64] !== 1'b0) begin
         fails++; $display("FAIL drain_end vld=%b want 0", instruction_reg[64]);
      end
   endtask

   task automatic test_full_pop_ready();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h200 + 32'(i * 4), 1'b0, 1'b0);
         tick();
      end
      drive(1'b1, 32'h210, 1'b1, 1'b0);
      tick();
      tests++;
      if (instruction_reg !== exp_ir(32'h200) || occupancy !== 3'd3 || if_ready !== 1'b1) begin
         fails++; $display("FAIL full_pop ir=%h occ=%0d rdy=%b want ir=%h occ=3 rdy=1",
                           instruction_reg, occupancy, if_ready, exp_ir(32'h200));
      end
      tick();
      tests++;
      if (instruction_reg !== exp_ir(32'h204) || occupancy !== 3'd3) begin
         fails++; $display("FAIL push_pop ir=%h occ=%0d want ir=%h occ=3",
                           instruction_reg, occupancy, exp_ir(32'h204));
      end
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++;
         if (instruction_reg !== exp_ir(32'h208 + 32'(i * 4))) begin
            fails++; $display("FAIL late_drain_%0d ir=%h want %h",
                              i, instruction_reg, exp_ir(32'h208 + 32'(i * 4)));
         end
      end
      tick();
   endtask

   task automatic test_wrap();
      drive(1'b1, 32'h0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'h4, 1'b0, 1'b0);
      tick();
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 32'(8 + i * 4), 1'b1, 1'b0);
         tick();
         tests++;
         if (instruction_reg !== exp_ir(32'(i * 4)) || occupancy !== 3'd2) begin
            fails++; $display("FAIL wrap_%0d ir=%h occ=%0d want ir=%h occ=2",
                              i, instruction_reg, occupancy, exp_ir(32'(i * 4)));
         end
      end
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) begin
         tick();
         tests++;
         if (instruction_reg !== exp_ir(32'h28 + 32'(i * 4))) begin
            fails++; $display("FAIL wrap_tail_%0d ir=%h want %h",
                              i, instruction_reg, exp_ir(32'h28 + 32'(i * 4)));
         end
      end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h30 + 32'(i * 4), 1'b0, 1'b0);
         tick();
      end
      tests++;
      if (occupancy !== 3'd3) begin
         fails++; $display("FAIL flush_pre occ=%0d want 3", occupancy);
      end
      drive(1'b1, 32'h40, 1'b1, 1'b1);
      tick();
      tests++;
      if (occupancy !== 3'd0 || instruction_reg !== {1'b0, 32'h2C, instr_of(32'h2C)}) begin
         fails++; $display("FAIL flush occ=%0d ir=%h want occ=0 ir=%h",
                           occupancy, instruction_reg, {1'b0, 32'h2C, instr_of(32'h2C)});
      end
      drive(1'b1, 32'h80, 1'b1, 1'b0);
      tick();
      tests++;
      if (instruction_reg !== exp_ir(32'h80) || occupancy !== 3'd0) begin
         fails++; $display("FAIL flush_bypass ir=%h occ=%0d want ir=%h occ=0",
                           instruction_reg, occupancy, exp_ir(32'h80));
      end
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      tick();
      tests++;
      if (instruction_reg[64] !== 1'b0) begin
         fails++; $display("FAIL flush_drop ir=%h want valid=0", instruction_reg);
      end
   endtask

   task automatic test_gated_clock_reset();
      drive(1'b1, 32'h90, 1'b0, 1'b0);
      tick();
      clk_en = 1'b0;
      drive(1'b1, 32'h94, 1'b1, 1'b0);
      repeat (5) tick();
      tests++;
      if (occupancy !== 3'd1 || instruction_reg !== {1'b0, 32'h80, instr_of(32'h80)}) begin
         fails++; $display("FAIL gated occ=%0d ir=%h want occ=1 ir=%h",
                           occupancy, instruction_reg, {1'b0, 32'h80, instr_of(32'h80)});
      end
      @(negedge aon_clk);
      clk_en = 1'b1;
      tick();
      tests++;
      if (instruction_reg !== exp_ir(32'h90) || occupancy !== 3'd1) begin
         fails++; $display("FAIL ungated ir=%h occ=%0d want ir=%h occ=1",
                           instruction_reg, occupancy, exp_ir(32'h90));
      end
      #2;
      i_rstn = 1'b0;
      #1;
      tests++;
      if (instruction_reg !== 65'd0 || occupancy !== 3'd0 || if_ready !== 1'b1) begin
         fails++; $display("FAIL async_reset ir=%h occ=%0d rdy=%b want 0/0/1",
                           instruction_reg, occupancy, if_ready);
      end
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      @(negedge aon_clk);
      i_rstn = 1'b1;
   endtask

   initial begin
      tests    = 0;
      fails    = 0;
      clk_en   = 1'b1;
      i_rstn   = 1'b0;
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      repeat (2) tick();
      test_reset();
      @(negedge aon_clk);
      i_rstn = 1'b1;
      tick();
      test_bypass();
      test_fill();
      test_drain();
      test_full_pop_ready();
      test_wrap();
      test_flush();
      test_gated_clock_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
